shift_ctrl_port: RTL and testbench

- Bus-facing register front-end for the shift I/O device on the Maquina Sencilla I/O bus; sits directly upstream of the shifter.
- The CPU writes the operand and the command (direction, count, start bit).
- The block issues a one-cycle start pulse to the shifter and waits for its ready.
- It captures the result and exposes busy/done/error status through memory-mapped registers.

---
 rtl/shift_io_pkg.sv | 20 ++
 rtl/shift_ctrl_timeout.sv | 24 ++
 rtl/shift_ctrl_port.sv | 150 +++++++++++++++
 tb/tb_shift_ctrl_port.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_io_pkg.sv
// shift_io_pkg: register map, status bit positions and FSM encoding shared
// by the shift I/O bus front-end.
package shift_io_pkg;
  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_RESULT = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  localparam int CTRL_START_BIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } ctrl_state_e;
endpackage

// File: rtl/shift_ctrl_timeout.sv
// shift_ctrl_timeout: clearable up-counter with a terminal-count flag that
// bounds how long the front-end waits for the shifter.
module shift_ctrl_timeout #(
  parameter int LIMIT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);
  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] r_cnt;

  // Clear has priority over increment; the count simply wraps if left running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_tc = (r_cnt == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/shift_ctrl_port.sv
// shift_ctrl_port: memory-mapped front-end that loads the shifter operand and
// command, pulses sh_start, waits for a fresh sh_ready rise (or times out)
// and exposes busy/done/err status with read-to-clear semantics.
// Optional macro SHIFT_CTRL_IRQ_EN adds a sticky irq output.
module shift_ctrl_port
  import shift_io_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMES_W = 4,
  parameter int TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs,
  input  logic               we,
  input  logic [1:0]         addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata,
  output logic [DATA_W-1:0]  sh_value,
  output logic               sh_direction,
  output logic [TIMES_W-1:0] sh_times,
  output logic               sh_start,
  input  logic [DATA_W-1:0]  sh_result,
  input  logic               sh_ready
`ifdef SHIFT_CTRL_IRQ_EN
  ,
  output logic               irq
`endif
);
  ctrl_state_e        r_state;
  logic [DATA_W-1:0]  r_value, r_result, r_rdata;
  logic               r_dir, r_done, r_err, r_start, r_ready_q;
  logic [TIMES_W-1:0] r_times;
  logic [DATA_W-1:0]  w_ctrl_rd, w_stat_rd;
  logic               w_tc;

  wire w_wr       = cs & we;
  wire w_rd       = cs & ~we;
  wire w_busy     = (r_state != ST_IDLE);
  wire w_wait     = (r_state == ST_WAIT);
  wire w_load     = (r_state == ST_LOAD);
  wire w_wr_value = w_wr & (addr == ADDR_VALUE);
  wire w_wr_ctrl  = w_wr & (addr == ADDR_CTRL);
  wire w_rd_stat  = w_rd & (addr == ADDR_STATUS);
  wire w_go       = w_wr_ctrl & ~w_busy & wdata[CTRL_START_BIT];
  // Only a low-to-high transition seen while waiting counts as completion.
  wire w_rise     = sh_ready & ~r_ready_q;
  wire w_cap      = w_wait & w_rise;
  wire w_tmo      = w_wait & ~w_rise & w_tc;
  wire w_bad_wr   = w_busy & (w_wr_value | w_wr_ctrl);
  wire w_set_err  = w_tmo | w_bad_wr;

  shift_ctrl_timeout #(.LIMIT(TIMEOUT)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_load),
    .i_inc (w_wait),
    .o_tc  (w_tc)
  );

  // Read-back views of CTRL (start always reads 0) and STATUS.
  always_comb begin
    w_ctrl_rd            = '0;
    w_ctrl_rd[0]         = r_dir;
    w_ctrl_rd[TIMES_W:1] = r_times;
    w_stat_rd            = '0;
    w_stat_rd[STAT_BUSY] = w_busy;
    w_stat_rd[STAT_DONE] = r_done;
    w_stat_rd[STAT_ERR]  = r_err;
  end

  // Control FSM; sh_start is registered and high only for the LOAD cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_start <= 1'b0;
    end else begin
      r_start <= w_go;
      unique case (r_state)
        ST_IDLE: if (w_go) r_state <= ST_LOAD;
        ST_LOAD: r_state <= ST_WAIT;
        ST_WAIT: if (w_cap | w_tmo) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Operand/command registers accept writes only while idle; result on capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_value  <= '0;
      r_dir    <= 1'b0;
      r_times  <= '0;
      r_result <= '0;
    end else begin
      if (w_wr_value & ~w_busy) r_value <= wdata;
      if (w_wr_ctrl & ~w_busy) begin
        r_dir   <= wdata[0];
        r_times <= wdata[TIMES_W:1];
      end
      if (w_cap) r_result <= sh_result;
    end
  end

  // Sticky flags: cleared by STATUS read or a new start, but a set on the same edge wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_cap | (r_done & ~w_rd_stat & ~w_go);
      r_err  <= w_set_err | (r_err & ~w_rd_stat & ~w_go);
    end
  end

  // Registered read data, sampled from pre-edge register values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rdata <= '0;
    else if (w_rd) begin
      unique case (addr)
        ADDR_VALUE:  r_rdata <= r_value;
        ADDR_CTRL:   r_rdata <= w_ctrl_rd;
        ADDR_RESULT: r_rdata <= r_result;
        default:     r_rdata <= w_stat_rd;
      endcase
    end
  end

  // Previous sh_ready sample for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ready_q <= 1'b0;
    else        r_ready_q <= sh_ready;
  end

`ifdef SHIFT_CTRL_IRQ_EN
  logic r_irq;
  // irq follows any done/err set and is dropped by a STATUS read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_irq <= 1'b0;
    else        r_irq <= w_cap | w_set_err | (r_irq & ~w_rd_stat);
  end
  assign irq = r_irq;
`endif

  assign rdata        = r_rdata;
  assign sh_value     = r_value;
  assign sh_direction = r_dir;
  assign sh_times     = r_times;
  assign sh_start     = r_start;
endmodule

// File: tb/tb_shift_ctrl_port.sv
// tb_shift_ctrl_port: directed register-map scenarios followed by random bus
// and shifter-stub traffic, all compared against a behavioural model.
module tb_shift_ctrl_port;
  localparam int TIMEOUT = 32;

  logic        clk = 1'b0, reset = 1'b1, cs = 1'b0, we = 1'b0, sh_ready = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [15:0] wdata = 16'd0, sh_result = 16'd0;
  wire  [15:0] rdata, sh_value;
  wire  [3:0]  sh_times;
  wire         sh_direction, sh_start;
`ifdef SHIFT_CTRL_IRQ_EN
  wire         irq;
`endif

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;

  shift_ctrl_port #(.DATA_W(16), .TIMES_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .sh_value(sh_value), .sh_direction(sh_direction),
    .sh_times(sh_times), .sh_start(sh_start), .sh_result(sh_result),
    .sh_ready(sh_ready)
`ifdef SHIFT_CTRL_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_value = 0, m_result = 0, m_rdata = 0;
  logic [3:0]  m_times = 0;
  logic        m_dir = 0, m_done = 0, m_err = 0, m_irq = 0, m_prev_ready = 0;
  bit          m_pulse = 0, m_waiting = 0;
  int          m_waited = 0;

  task automatic model_step();
    logic busy, rise, go, rd_stat, set_d, set_e;
    busy    = m_pulse || m_waiting;
    rise    = sh_ready && !m_prev_ready;
    rd_stat = cs && !we && (addr == 2'd3);
    go = 0; set_d = 0; set_e = 0;
    if (cs && !we) begin
      case (addr)
        2'd0: m_rdata = m_value;
        2'd1: m_rdata = {11'd0, m_times, m_dir};
        2'd2: m_rdata = m_result;
        default: m_rdata = {13'd0, m_err, m_done, busy};
      endcase
    end
    if (cs && we && addr <= 2'd1) begin
      if (busy) set_e = 1;
      else if (addr == 2'd0) m_value = wdata;
      else begin
        m_dir = wdata[0]; m_times = wdata[4:1]; go = wdata[15];
      end
    end
    if (m_pulse) begin
      m_pulse = 0; m_waiting = 1; m_waited = 0;
    end else if (m_waiting) begin
      if (rise) begin m_result = sh_result; set_d = 1; m_waiting = 0; end
      else if (m_waited == TIMEOUT - 1) begin set_e = 1; m_waiting = 0; end
      else m_waited++;
    end
    if (go) m_pulse = 1;
    if (rd_stat || go) begin m_done = 0; m_err = 0; end
    if (rd_stat) m_irq = 0;
    if (set_d) begin m_done = 1; m_irq = 1; end
    if (set_e) begin m_err = 1; m_irq = 1; end
    m_prev_ready = sh_ready;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_value = 0; m_result = 0; m_rdata = 0; m_times = 0; m_dir = 0;
      m_done = 0; m_err = 0; m_irq = 0; m_prev_ready = 0;
      m_pulse = 0; m_waiting = 0; m_waited = 0;
    end else model_step();
  end

  // Compare every cycle on the inactive edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rdata", rdata, m_rdata);
      check("sh_value", sh_value, m_value);
      check("sh_direction", {15'd0, sh_direction}, {15'd0, m_dir});
      check("sh_times", {12'd0, sh_times}, {12'd0, m_times});
      check("sh_start", {15'd0, sh_start}, {15'd0, m_pulse});
`ifdef SHIFT_CTRL_IRQ_EN
      check("irq", {15'd0, irq}, {15'd0, m_irq});
`endif
    end
  end

  // ---------------- stimulus helpers (called #1 after a posedge) ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    cs = 1; we = 1; addr = a; wdata = d;
    @(posedge clk); #1;
    cs = 0; we = 0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    cs = 1; we = 0; addr = a;
    @(posedge clk); #1;
    cs = 0;
    d = rdata;
  endtask

  logic [15:0] rd;

  initial begin
    #2 reset = 0;
    chk_en = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    idle(1);

    // reset state
    bus_read(2'd2, rd); check("reset_result", rd, 16'h0000);
    bus_read(2'd3, rd); check("reset_status", rd, 16'h0000);

    // basic shift with ready after 6 cycles
    bus_write(2'd0, 16'h00F0);
    bus_write(2'd1, 16'h8009);
    check("start_pulse", {15'd0, sh_start}, 16'h0001);
    check("start_value", sh_value, 16'h00F0);
    check("start_dir", {15'd0, sh_direction}, 16'h0001);
    check("start_times", {12'd0, sh_times}, 16'h0004);
    idle(1);
    check("start_one_cycle", {15'd0, sh_start}, 16'h0000);
    idle(5);
    sh_ready = 1; sh_result = 16'h000F;
    idle(1);
    sh_ready = 0;
    bus_read(2'd2, rd); check("result_0f", rd, 16'h000F);
    bus_read(2'd3, rd); check("status_done", rd, 16'h0002);
    bus_read(2'd3, rd); check("status_cleared", rd, 16'h0000);
    bus_read(2'd1, rd); check("ctrl_readback", rd, 16'h0009);

    // write while busy: ignored and flagged
    bus_write(2'd1, 16'h8003);
    bus_write(2'd1, 16'h8015);
    check("busy_no_restart", {15'd0, sh_start}, 16'h0000);
    check("busy_times_kept", {12'd0, sh_times}, 16'h0001);
    idle(2);
    sh_ready = 1; sh_result = 16'h1234;
    idle(1);
    sh_ready = 0;
    bus_read(2'd3, rd); check("status_done_err", rd, 16'h0006);

    // timeout boundary: busy through the 32nd WAIT cycle, then err
    bus_write(2'd1, 16'h8001);
    idle(31);
    bus_read(2'd3, rd); check("tmo_still_busy", rd, 16'h0001);
    bus_read(2'd3, rd); check("tmo_last_wait", rd, 16'h0001);
    bus_read(2'd3, rd); check("tmo_err", rd, 16'h0004);
    bus_read(2'd3, rd); check("tmo_err_cleared", rd, 16'h0000);
    bus_read(2'd2, rd); check("tmo_result_kept", rd, 16'h1234);

    // ready already high at start: not accepted
    sh_ready = 1; sh_result = 16'hBEEF;
    idle(1);
    bus_write(2'd1, 16'h8001);
    idle(40);
    bus_read(2'd3, rd); check("held_ready_tmo", rd, 16'h0004);
    bus_read(2'd2, rd); check("held_ready_nocap", rd, 16'h1234);

    // drop and re-raise ready in WAIT: captured
    bus_write(2'd1, 16'h8001);
    idle(3);
    sh_ready = 0;
    idle(1);
    sh_ready = 1; sh_result = 16'h5555;
    idle(1);
`ifdef SHIFT_CTRL_IRQ_EN
    check("irq_set", {15'd0, irq}, 16'h0001);
`endif
    bus_read(2'd3, rd); check("rerise_done", rd, 16'h0002);
`ifdef SHIFT_CTRL_IRQ_EN
    check("irq_cleared", {15'd0, irq}, 16'h0000);
`endif
    bus_read(2'd2, rd); check("rerise_result", rd, 16'h5555);
    sh_ready = 0;

    // asynchronous reset in the middle of an operation
    bus_read(2'd0, rd); check("value_before_rst", rd, 16'h00F0);
    bus_write(2'd1, 16'h8001);
    #1 reset = 0;
    #1;
    check("rst_sh_start", {15'd0, sh_start}, 16'h0000);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_value", sh_value, 16'h0000);
    idle(2);
    reset = 1;
    idle(1);
    bus_read(2'd3, rd); check("rst_status", rd, 16'h0000);
    bus_read(2'd2, rd); check("rst_result", rd, 16'h0000);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      int seg;
      seg = (c / 250) % 3;
      cs = ($urandom_range(0, 2) == 0);
      we = 1'($urandom_range(0, 1));
      addr = 2'($urandom_range(0, 3));
      wdata = 16'($urandom);
      if ($urandom_range(0, (seg == 2) ? 63 : 4) == 0) sh_ready = ~sh_ready;
      sh_result = 16'($urandom);
      @(posedge clk); #1;
    end
    cs = 0; we = 0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
